xlr8_dmem_arb: RTL and testbench
================================

XLR8_DMEM_ARB -- requirements
Module: xlr8_dmem_arb

Interface
REQ-001 Parameter XLR8DMEM_SIZE, default 1024: number of implemented bytes in the shared single-port dmem (1024..65536).
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rstn  input  1  reset; asynchronous, active-low.
REQ-004 a_re, a_we  input  1 each  CPU-side access strobes; never asserted together.
REQ-005 a_addr  input  16  CPU-side byte address.
REQ-006 a_wdata  input  8  CPU-side write data.
REQ-007 a_rdata  output  8  CPU-side read data, valid the cycle after a_re.
REQ-008 b_req  input  1  burst start request, sampled only in IDLE.
REQ-009 b_we  input  1  burst direction (1 = write, 0 = read), sampled with b_req.
REQ-010 b_addr  input  16  burst start address, sampled with b_req.
REQ-011 b_len  input  8  burst beat count, sampled with b_req; 0 means 256.
REQ-012 b_wdata  input  8  write-beat data, consumed when b_wready is high.
REQ-013 b_wready  output  1  write beat accepted this cycle.
REQ-014 b_rdata  output  8  read-beat data.
REQ-015 b_rvalid  output  1  b_rdata valid this cycle.
REQ-016 b_busy  output  1  burst in progress (state not IDLE).
REQ-017 b_done  output  1  one-cycle burst-complete pulse.
REQ-018 b_err  output  1  sticky out-of-range flag, cleared on the next accepted b_req.
REQ-019 stall_cnt  output  16  preemption counter (see Configuration).
REQ-020 mem_addr  output  16,  mem_din  output  8,  mem_we  output  1,  mem_dout  input  8: dmem port with 1-cycle registered read latency.

Function
REQ-021 Port A has absolute priority: in any cycle with a_re or a_we, mem_addr=a_addr, mem_din=a_wdata, mem_we=a_we, and no B beat issues.
REQ-022 a_rdata shall equal mem_dout unconditionally.
REQ-023 The FSM shall have states IDLE, BURST and DRAIN.
REQ-024 IDLE -> BURST on b_req; that edge loads cur_addr=b_addr, remaining=b_len (0 loads 256), dir=b_we, clears b_err, and clears stall_cnt.
REQ-025 In BURST, each cycle without an A access issues one beat at mem_addr=cur_addr; after the beat, cur_addr increments by 1 mod 2^16 and remaining decrements.
REQ-026 Write beat: b_wready=1 combinationally in the issuing cycle, with mem_din=b_wdata and mem_we=1; b_wready=0 in every other cycle.
REQ-027 Read beat: b_rvalid=1 exactly one cycle after issue, with b_rdata=mem_dout.
REQ-028 Out-of-range beat (cur_addr >= XLR8DMEM_SIZE): the beat is still consumed and counted, mem_we is forced 0, the returned b_rdata is 8'h00, and b_err is set.
REQ-029 BURST -> DRAIN on the edge after the last beat issues; DRAIN lasts one cycle with b_done=1 (coincident with the last b_rvalid for reads), then goes to IDLE.
REQ-030 b_req asserted outside IDLE shall be ignored; b_busy=1 in BURST and DRAIN.
REQ-031 An A access in the cycle a beat would issue defers that beat by one cycle; address and count do not change.
REQ-032 When idle and A is inactive, mem_addr holds its last value and mem_we=0.

Reset
REQ-033 Assertion of rstn at any time, including mid-burst, forces IDLE and clears cur_addr, remaining, b_wready, b_rvalid, b_busy, b_done, b_err, stall_cnt and mem_we to 0; mem_addr resets to 0.
REQ-034 A burst interrupted by reset shall not complete after rstn deasserts and shall produce no b_done.

Configuration
REQ-035 With XLR8DMEM_ARB_STATS_EN defined, stall_cnt counts BURST cycles in which an A access deferred a beat, saturating at 16'hFFFF.
REQ-036 Without XLR8DMEM_ARB_STATS_EN, stall_cnt is tied to 16'h0000 and no counter logic is built.

Verification
REQ-037 Write burst b_addr=16'h0010, b_len=4, A idle -> 4 consecutive b_wready pulses; mem 0x10..0x13 written; b_done 1 cycle after the last beat.
REQ-038 Read burst of the same range -> 4 b_rvalid pulses returning the written data in order; b_done coincides with the 4th b_rvalid.
REQ-039 Read burst b_len=8 with a_re asserted on beats 2 and 5 -> 2 deferrals, 10 BURST cycles total, A data correct, stall_cnt=2 (STATS_EN) or 0 (no STATS_EN).
REQ-040 SIZE=1024, b_addr=16'h03FE, b_len=4, write -> writes land at 0x3FE and 0x3FF only; b_err=1; 4 b_wready pulses; b_done pulses.
REQ-041 b_len=0 from 16'hFFFF -> 256 beats with address wrap to 16'h0000; b_req re-pulsed mid-burst is ignored.
REQ-042 rstn pulsed low after beat 3 of an 8-beat burst -> all outputs return to reset values; b_busy=0 and no b_done after release.

Source files
------------

// File: rtl/xlr8_dmem_arb.sv
// Single-port dmem arbiter: CPU port A has absolute priority; port B runs incrementing bursts.
// Optional preemption statistics are built when XLR8DMEM_ARB_STATS_EN is defined.
module xlr8_dmem_arb #(
  parameter int XLR8DMEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        a_re,
  input  logic        a_we,
  input  logic [15:0] a_addr,
  input  logic [7:0]  a_wdata,
  output logic [7:0]  a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [15:0] b_addr,
  input  logic [7:0]  b_len,
  input  logic [7:0]  b_wdata,
  output logic        b_wready,
  output logic [7:0]  b_rdata,
  output logic        b_rvalid,
  output logic        b_busy,
  output logic        b_done,
  output logic        b_err,
  output logic [15:0] stall_cnt,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_we,
  input  logic [7:0]  mem_dout
);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  localparam logic [16:0] SIZE_EXT = 17'(XLR8DMEM_SIZE);

  state_t      state, state_nxt;
  logic [15:0] cur_addr;
  logic [8:0]  remaining;
  logic        dir;
  logic [15:0] hold_addr;
  logic        a_act, accept, issue, oor;
  logic        vld_p0, oor_p0;

  assign a_act  = a_re | a_we;
  assign accept = (state == IDLE) & b_req;
  assign oor    = {1'b0, cur_addr} >= SIZE_EXT;

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    b_done    = 1'b0;
    case (state)
      IDLE:  if (b_req) state_nxt = BURST;
      BURST: begin
        if (!a_act) begin
          issue = 1'b1;
          if (remaining == 9'd1) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        b_done    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // p0: beat issue -> burst bookkeeping and read-return tag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur_addr  <= 16'h0000;
      remaining <= 9'd0;
      dir       <= 1'b0;
      b_err     <= 1'b0;
      hold_addr <= 16'h0000;
      vld_p0    <= 1'b0;
      oor_p0    <= 1'b0;
    end else begin
      hold_addr <= mem_addr;
      vld_p0    <= issue & ~dir;
      oor_p0    <= oor;
      if (accept) begin
        cur_addr  <= b_addr;
        remaining <= (b_len == 8'd0) ? 9'd256 : {1'b0, b_len};
        dir       <= b_we;
        b_err     <= 1'b0;
      end else if (issue) begin
        cur_addr  <= cur_addr + 16'd1;
        remaining <= remaining - 9'd1;
        if (oor) b_err <= 1'b1;
      end
    end
  end

  // Out-of-range beats still consume a slot but never write the array.
  assign mem_addr = a_act ? a_addr  : (issue ? cur_addr : hold_addr);
  assign mem_din  = a_act ? a_wdata : b_wdata;
  assign mem_we   = a_act ? a_we    : (issue & dir & ~oor);

  assign b_wready = issue & dir;
  assign b_rvalid = vld_p0;
  assign b_rdata  = oor_p0 ? 8'h00 : mem_dout;
  assign a_rdata  = mem_dout;
  assign b_busy   = (state != IDLE);

`ifdef XLR8DMEM_ARB_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_q <= 16'h0000;
    end else if (accept) begin
      stall_q <= 16'h0000;
    end else if ((state == BURST) && a_act && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_xlr8_dmem_arb.sv
// Bench for xlr8_dmem_arb: table of bursts with an independent beat model, read-data
// scoreboard queue, byte-array dmem model, plus a reset-mid-burst sequence.
module tb_xlr8_dmem_arb;

  localparam int SIZE = 1024;
  localparam logic [15:0] AADDR = 16'h0012;
`ifdef XLR8DMEM_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        a_re, a_we;
  logic [15:0] a_addr;
  logic [7:0]  a_wdata, a_rdata;
  logic        b_req, b_we;
  logic [15:0] b_addr;
  logic [7:0]  b_len, b_wdata, b_rdata;
  logic        b_wready, b_rvalid, b_busy, b_done, b_err;
  logic [15:0] stall_cnt, mem_addr;
  logic [7:0]  mem_din, mem_dout;
  logic        mem_we;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:65535];
  logic [7:0] ref_mem [0:65535];
  logic       loaded = 1'b0;

  always #5 clk = ~clk;

  xlr8_dmem_arb #(.XLR8DMEM_SIZE(SIZE)) dut (
    .clk(clk), .rstn(rstn),
    .a_re(a_re), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_len(b_len), .b_wdata(b_wdata),
    .b_wready(b_wready), .b_rdata(b_rdata), .b_rvalid(b_rvalid), .b_busy(b_busy),
    .b_done(b_done), .b_err(b_err), .stall_cnt(stall_cnt),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
  );

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // dmem model: one-cycle registered read, read-before-write
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 65536; i++) mem[i] <= pat(16'(i));
      loaded <= 1'b1;
    end else begin
      if (mem_we) mem[mem_addr] <= mem_din;
      mem_dout <= mem[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  len;
    logic [15:0] dmask;
    logic        repulse;
    int          exp_cyc;
    int          exp_wr;
    int          exp_rv;
    logic        exp_err;
    int          exp_def;
  } vec_t;

  vec_t vecs [7];

  task automatic run_vec(input vec_t v);
    int          left, idx, cyc, nwr, nrv, mism;
    logic [15:0] cur, last;
    logic        beat, dflag, rd_prev, a_prev, exp_we;
    logic [7:0]  a_exp, rexp;
    logic [7:0]  q [$];
    left = (v.len == 8'd0) ? 256 : int'(v.len);
    @(negedge clk);
    b_req = 1'b1; b_we = v.we; b_addr = v.addr; b_len = v.len; a_re = 1'b0;
    @(negedge clk);
    cur = v.addr; last = v.addr; idx = 0; cyc = 0; nwr = 0; nrv = 0;
    dflag = 1'b0; rd_prev = 1'b0; a_prev = 1'b0; a_exp = 8'h00;
    while (left > 0) begin
      b_req  = v.repulse && (idx == 100);
      b_addr = b_req ? 16'h0200 : v.addr;
      beat   = !((idx < 16) && v.dmask[idx] && !dflag);
      a_re   = !beat;
      a_addr = AADDR;
      exp_we = v.we && (int'(cur) < SIZE);
      if (beat) begin
        if (v.we) begin
          b_wdata = pat(cur) ^ 8'hC3;
          if (int'(cur) < SIZE) ref_mem[cur] = b_wdata;
        end else begin
          q.push_back((int'(cur) < SIZE) ? ref_mem[cur] : 8'h00);
        end
      end
      #1;
      chk("busy", b_busy, 1);
      chk("done_early", b_done, 0);
      chk("rvalid", b_rvalid, rd_prev);
      if (b_rvalid) nrv++;
      if (rd_prev && b_rvalid && q.size() > 0) begin
        rexp = q.pop_front();
        chk("rdata", b_rdata, rexp);
      end
      if (a_prev) chk("a_rdata", a_rdata, a_exp);
      if (beat) begin
        chk("beat_mem_addr", mem_addr, cur);
        chk("beat_mem_we", mem_we, exp_we);
        chk("beat_wready", b_wready, v.we);
        if (b_wready) nwr++;
        last = cur; cur = cur + 16'd1; left--; idx++; dflag = 1'b0;
      end else begin
        chk("a_mem_addr", mem_addr, AADDR);
        chk("a_mem_we", mem_we, 0);
        chk("defer_wready", b_wready, 0);
        dflag = 1'b1;
      end
      rd_prev = beat && !v.we;
      a_prev  = !beat;
      a_exp   = ref_mem[AADDR];
      cyc++;
      @(negedge clk);
    end
    b_req = 1'b0; a_re = 1'b0; b_addr = v.addr;
    #1;
    chk("done", b_done, 1);
    chk("busy_drain", b_busy, 1);
    chk("wready_drain", b_wready, 0);
    chk("rvalid_drain", b_rvalid, rd_prev);
    if (b_rvalid) nrv++;
    if (rd_prev && b_rvalid && q.size() > 0) begin
      rexp = q.pop_front();
      chk("rdata_last", b_rdata, rexp);
    end
    if (a_prev) chk("a_rdata", a_rdata, a_exp);
    @(negedge clk);
    #1;
    chk("idle_busy", b_busy, 0);
    chk("idle_done", b_done, 0);
    chk("idle_rvalid", b_rvalid, 0);
    chk("idle_mem_we", mem_we, 0);
    chk("idle_mem_addr_hold", mem_addr, last);
    chk("err", b_err, v.exp_err);
    chk("stall_cnt", stall_cnt, STATS ? v.exp_def : 0);
    chk("burst_cycles", cyc, v.exp_cyc);
    chk("wready_count", nwr, v.exp_wr);
    chk("rvalid_count", nrv, v.exp_rv);
    chk("rd_queue_empty", q.size(), 0);
    mism = 0;
    for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) mism++;
    chk("mem_image", mism, 0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ref_mem[i] = pat(16'(i));
    vecs[0] = '{1'b1, 16'h0010, 8'd4, 16'h0000, 1'b0,   4, 4,   0, 1'b0, 0};
    vecs[1] = '{1'b0, 16'h0010, 8'd4, 16'h0000, 1'b0,   4, 0,   4, 1'b0, 0};
    vecs[2] = '{1'b0, 16'h0010, 8'd8, 16'h0012, 1'b0,  10, 0,   8, 1'b0, 2};
    vecs[3] = '{1'b1, 16'h03FE, 8'd4, 16'h0000, 1'b0,   4, 4,   0, 1'b1, 0};
    vecs[4] = '{1'b0, 16'h03FE, 8'd4, 16'h0000, 1'b0,   4, 0,   4, 1'b1, 0};
    vecs[5] = '{1'b0, 16'hFFFF, 8'd0, 16'h0000, 1'b1, 256, 0, 256, 1'b1, 0};
    vecs[6] = '{1'b1, 16'h0100, 8'd3, 16'h0001, 1'b0,   4, 3,   0, 1'b0, 1};

    rstn = 1'b0; a_re = 1'b0; a_we = 1'b0; a_addr = 16'h0000; a_wdata = 8'h00;
    b_req = 1'b0; b_we = 1'b0; b_addr = 16'h0000; b_len = 8'd0; b_wdata = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", b_busy, 0);
    chk("rst_done", b_done, 0);
    chk("rst_err", b_err, 0);
    chk("rst_wready", b_wready, 0);
    chk("rst_rvalid", b_rvalid, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    @(negedge clk);
    rstn = 1'b1;

    for (int n = 0; n < 7; n++) run_vec(vecs[n]);

    // Reset asserted after the third beat of an 8-beat read burst
    @(negedge clk);
    b_req = 1'b1; b_we = 1'b0; b_addr = 16'h0020; b_len = 8'd8;
    @(negedge clk);
    b_req = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("mid_rst_busy", b_busy, 0);
    chk("mid_rst_done", b_done, 0);
    chk("mid_rst_rvalid", b_rvalid, 0);
    chk("mid_rst_wready", b_wready, 0);
    chk("mid_rst_err", b_err, 0);
    chk("mid_rst_stall", stall_cnt, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_mem_we", mem_we, 0);
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      #1;
      chk("post_rst_busy", b_busy, 0);
      chk("post_rst_done", b_done, 0);
      chk("post_rst_rvalid", b_rvalid, 0);
    end
    chk("post_rst_mem_addr", mem_addr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
